// File: rtl/dff_mem_cmd_seq_if.sv
// Bus bundle between the command sequencer and its environment:
// the byte command stream in, the read-back stream out, and the memory port.
interface dff_mem_cmd_seq_if #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_W    = 8
);
   logic [DATA_W-1:0]    in_data;
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    out_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [ADDR_BITS-1:0] mem_addr;
   logic                 mem_wr_en;
   logic                 mem_rd_en;
   logic [DATA_W-1:0]    mem_wdata;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 busy;
   logic                 err;
   logic [2:0]           state_dbg;

   // Sequencer side.
   modport master (
      input  in_data, in_valid, out_ready, mem_rdata,
      output in_ready, out_data, out_valid, mem_addr, mem_wr_en, mem_rd_en,
             mem_wdata, busy, err, state_dbg
   );

   // Environment side: stream source/sink and the memory.
   modport slave (
      output in_data, in_valid, out_ready, mem_rdata,
      input  in_ready, out_data, out_valid, mem_addr, mem_wr_en, mem_rd_en,
             mem_wdata, busy, err, state_dbg
   );
endinterface

// File: rtl/dff_mem_cmd_seq.sv
// Byte-stream command sequencer driving a 16-byte DFF register-file memory:
// decodes WRITE/READ/NOP bursts and returns read bytes on a valid/ready stream.
module dff_mem_cmd_seq #(
   parameter int ADDR_BITS = 4,
   parameter int DATA_W    = 8
) (
   input logic                clk,
   input logic                rst,
   dff_mem_cmd_seq_if.master  bus
);
   // Both streams use the same rule: a byte moves on a rising edge where
   // valid && ready; valid, once raised, holds with stable data until then.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WDATA  = 3'd1,
      RD_MEM = 3'd2,
      RD_CAP = 3'd3,
      RD_OUT = 3'd4
   } state_t;

   localparam logic [1:0] OP_NOP   = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WRITE = 2'b10;

   state_t               state;
   logic [ADDR_BITS-1:0] addr;
   logic [1:0]           count;    // bytes remaining after the current one
   logic [ADDR_BITS-1:0] addr_nxt;
   logic [1:0]           op;

   assign addr_nxt      = addr + ADDR_BITS'(1);
   assign op            = bus.in_data[7:6];
   assign bus.in_ready  = (state == IDLE) || (state == WDATA);
   assign bus.busy      = (state != IDLE);
   assign bus.state_dbg = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         addr          <= '0;
         count         <= '0;
         bus.mem_addr  <= '0;
         bus.mem_wr_en <= 1'b0;
         bus.mem_rd_en <= 1'b0;
         bus.mem_wdata <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
         bus.err       <= 1'b0;
      end else begin
         bus.mem_wr_en <= 1'b0;
         bus.err       <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  addr  <= bus.in_data[ADDR_BITS-1:0];
                  count <= bus.in_data[5:4];
                  case (op)
                     OP_WRITE: state <= WDATA;
                     OP_READ: begin
                        bus.mem_rd_en <= 1'b1;
                        bus.mem_addr  <= bus.in_data[ADDR_BITS-1:0];
                        state         <= RD_MEM;
                     end
                     OP_NOP:  state <= IDLE;
                     default: bus.err <= 1'b1;
                  endcase
               end
            end
            WDATA: begin
               if (bus.in_valid) begin
                  bus.mem_wr_en <= 1'b1;
                  bus.mem_addr  <= addr;
                  bus.mem_wdata <= bus.in_data;
                  addr          <= addr_nxt;
                  if (count == 2'd0) state <= IDLE;
                  else               count <= count - 2'd1;
               end
            end
            RD_MEM: begin
               bus.mem_rd_en <= 1'b0;
               state         <= RD_CAP;
            end
            RD_CAP: begin
               // Memory read data is registered, so it is valid one cycle after the strobe.
               bus.out_data  <= bus.mem_rdata;
               bus.out_valid <= 1'b1;
               state         <= RD_OUT;
            end
            RD_OUT: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  if (count != 2'd0) begin
                     count         <= count - 2'd1;
                     addr          <= addr_nxt;
                     bus.mem_rd_en <= 1'b1;
                     bus.mem_addr  <= addr_nxt;
                     state         <= RD_MEM;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dff_mem_cmd_seq.sv
// Directed bench for dff_mem_cmd_seq: a per-cycle vector table plus
// hand-written async-reset sequences, against a 16-byte memory model.
module tb_dff_mem_cmd_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   dff_mem_cmd_seq_if #(.ADDR_BITS(4), .DATA_W(8)) bus ();
   dff_mem_cmd_seq #(.ADDR_BITS(4), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

   // Memory model: write on the strobe, registered read data.
   logic [7:0] mem [16];
   initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
   always @(posedge clk) begin
      if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   typedef struct packed {
      logic       rdy;
      logic       busy;
      logic       wr;
      logic       rd;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic       ov;
      logic [7:0] od;
      logic       err;
   } outs_t;

   typedef struct packed {
      logic       iv;
      logic [7:0] id;
      logic       orr;
      outs_t      exp;
   } vec_t;

   vec_t vecs[$];

   function automatic outs_t sample();
      outs_t s;
      s.rdy   = bus.in_ready;
      s.busy  = bus.busy;
      s.wr    = bus.mem_wr_en;
      s.rd    = bus.mem_rd_en;
      s.addr  = bus.mem_addr;
      s.wdata = bus.mem_wdata;
      s.ov    = bus.out_valid;
      s.od    = bus.out_data;
      s.err   = bus.err;
      return s;
   endfunction

   task automatic add(input logic iv, input logic [7:0] id, input logic orr,
                      input logic rdy, input logic bsy, input logic wr, input logic rd,
                      input logic [3:0] a, input logic [7:0] wd, input logic ov,
                      input logic [7:0] od, input logic er);
      vec_t v;
      v.iv = iv; v.id = id; v.orr = orr;
      v.exp = '{rdy: rdy, busy: bsy, wr: wr, rd: rd, addr: a, wdata: wd,
                ov: ov, od: od, err: er};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input outs_t got, input outs_t exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got rdy=%b busy=%b wr=%b rd=%b addr=%h wd=%h ov=%b od=%h err=%b, want rdy=%b busy=%b wr=%b rd=%b addr=%h wd=%h ov=%b od=%h err=%b",
                  name, got.rdy, got.busy, got.wr, got.rd, got.addr, got.wdata, got.ov, got.od, got.err,
                  exp.rdy, exp.busy, exp.wr, exp.rd, exp.addr, exp.wdata, exp.ov, exp.od, exp.err);
      end
   endtask

   // The memory must never see both strobes in one cycle.
   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         if (bus.mem_wr_en && bus.mem_rd_en) begin
            n_bad++;
            $display("FAIL strobe_excl: wr=%b rd=%b, want not both", bus.mem_wr_en, bus.mem_rd_en);
         end
      end
   end

   outs_t idle0;
   int    waited;

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.out_ready = 1'b0;
      idle0 = '{rdy: 1'b1, busy: 1'b0, wr: 1'b0, rd: 1'b0, addr: 4'h0, wdata: 8'h00,
                ov: 1'b0, od: 8'h00, err: 1'b0};

      // Async reset asserted mid-cycle, checked before any clock edge.
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      #1 check("reset_async", sample(), idle0);
      @(negedge clk) rst = 1'b0;

      //  iv id     or  rdy bsy wr rd addr wdata  ov od     err
      // single write 0x83 / 0xA5
      add(1, 8'h83, 0,  1,  1,  0, 0, 4'h0, 8'h00, 0, 8'h00, 0);
      add(1, 8'hA5, 0,  1,  0,  1, 0, 4'h3, 8'hA5, 0, 8'h00, 0);
      add(0, 8'h00, 0,  1,  0,  0, 0, 4'h3, 8'hA5, 0, 8'h00, 0);
      // burst write 0xBE, wraps 14,15,0,1
      add(1, 8'hBE, 0,  1,  1,  0, 0, 4'h3, 8'hA5, 0, 8'h00, 0);
      add(1, 8'h11, 0,  1,  1,  1, 0, 4'hE, 8'h11, 0, 8'h00, 0);
      add(1, 8'h22, 0,  1,  1,  1, 0, 4'hF, 8'h22, 0, 8'h00, 0);
      add(1, 8'h33, 0,  1,  1,  1, 0, 4'h0, 8'h33, 0, 8'h00, 0);
      add(1, 8'h44, 0,  1,  0,  1, 0, 4'h1, 8'h44, 0, 8'h00, 0);
      add(0, 8'h00, 0,  1,  0,  0, 0, 4'h1, 8'h44, 0, 8'h00, 0);
      // read 0x4E with backpressure; offered input bytes must not be consumed
      add(1, 8'h4E, 0,  0,  1,  0, 1, 4'hE, 8'h44, 0, 8'h00, 0);
      add(1, 8'hC0, 0,  0,  1,  0, 0, 4'hE, 8'h44, 0, 8'h00, 0);
      add(1, 8'hC0, 0,  0,  1,  0, 0, 4'hE, 8'h44, 1, 8'h11, 0);
      add(1, 8'hC0, 0,  0,  1,  0, 0, 4'hE, 8'h44, 1, 8'h11, 0);
      add(1, 8'hC0, 0,  0,  1,  0, 0, 4'hE, 8'h44, 1, 8'h11, 0);
      add(0, 8'h00, 0,  0,  1,  0, 0, 4'hE, 8'h44, 1, 8'h11, 0);
      add(0, 8'h00, 1,  1,  0,  0, 0, 4'hE, 8'h44, 0, 8'h11, 0);
      // burst read 0x7E, one byte per 3 cycles
      add(1, 8'h7E, 1,  0,  1,  0, 1, 4'hE, 8'h44, 0, 8'h11, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'hE, 8'h44, 0, 8'h11, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'hE, 8'h44, 1, 8'h11, 0);
      add(0, 8'h00, 1,  0,  1,  0, 1, 4'hF, 8'h44, 0, 8'h11, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'hF, 8'h44, 0, 8'h11, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'hF, 8'h44, 1, 8'h22, 0);
      add(0, 8'h00, 1,  0,  1,  0, 1, 4'h0, 8'h44, 0, 8'h22, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'h0, 8'h44, 0, 8'h22, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'h0, 8'h44, 1, 8'h33, 0);
      add(0, 8'h00, 1,  0,  1,  0, 1, 4'h1, 8'h44, 0, 8'h33, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'h1, 8'h44, 0, 8'h33, 0);
      add(0, 8'h00, 1,  0,  1,  0, 0, 4'h1, 8'h44, 1, 8'h44, 0);
      add(0, 8'h00, 1,  1,  0,  0, 0, 4'h1, 8'h44, 0, 8'h44, 0);
      // illegal opcode pulses err once; NOP does nothing
      add(1, 8'hC0, 1,  1,  0,  0, 0, 4'h1, 8'h44, 0, 8'h44, 1);
      add(1, 8'h00, 1,  1,  0,  0, 0, 4'h1, 8'h44, 0, 8'h44, 0);
      add(0, 8'h00, 1,  1,  0,  0, 0, 4'h1, 8'h44, 0, 8'h44, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         bus.in_valid  = vecs[i].iv;
         bus.in_data   = vecs[i].id;
         bus.out_ready = vecs[i].orr;
         @(posedge clk);
         #1 check($sformatf("vec%0d", i), sample(), vecs[i].exp);
      end

      // Reset while a 4-byte read sits stalled in RD_OUT.
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_data = 8'h7E; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); @(posedge clk);
      #1 check("stall_before_rst", sample(),
               '{rdy: 1'b0, busy: 1'b1, wr: 1'b0, rd: 1'b0, addr: 4'hE, wdata: 8'h44,
                 ov: 1'b1, od: 8'h11, err: 1'b0});
      #2 rst = 1'b1;
      #1 check("reset_in_rd_out", sample(), idle0);
      @(negedge clk) rst = 1'b0;

      // Next command after reset: READ addr 1, len 1 -> 0x44 two edges after accept.
      bus.in_valid = 1'b1; bus.in_data = 8'h41; bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 10) begin
         @(posedge clk);
         #1 waited++;
      end
      n_cmp++;
      if (!bus.out_valid || waited != 2 || bus.out_data !== 8'h44) begin
         n_bad++;
         $display("FAIL read_after_rst: ov=%b cycles=%0d od=%h, want ov=1 cycles=2 od=44",
                  bus.out_valid, waited, bus.out_data);
      end
      @(posedge clk);
      #1 check("idle_after_rst_read", sample(),
               '{rdy: 1'b1, busy: 1'b0, wr: 1'b0, rd: 1'b0, addr: 4'h1, wdata: 8'h00,
                 ov: 1'b0, od: 8'h44, err: 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/dff_mem_cmd_seq.md
Name: dff_mem_cmd_seq

Overview:
Byte-stream command sequencer that sits directly upstream of the 16-byte DFF register-file memory. It drives that memory's address, write-strobe, read-strobe and write-data inputs, and consumes its registered read data. It turns a valid/ready byte stream of commands into single or burst memory writes and reads. It returns read bytes on a valid/ready output stream. It guarantees the memory never sees write and read asserted together.

Parameters:
ADDR_BITS, 4, memory address width; memory depth is 2**ADDR_BITS (16).
DATA_W, 8, data byte width.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous reset, active-high.
in_data  input  DATA_W  command/write-data byte.
in_valid  input  1  in_data valid.
in_ready  output  1  sequencer accepts in_data this cycle.
out_data  output  DATA_W  read-back byte.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts out_data.
mem_addr  output  ADDR_BITS  memory address.
mem_wr_en  output  1  memory write strobe, one-cycle pulse.
mem_rd_en  output  1  memory read strobe, one-cycle pulse.
mem_wdata  output  DATA_W  memory write data.
mem_rdata  input  DATA_W  memory registered read data, valid the cycle after the cycle mem_rd_en is high.
busy  output  1  high whenever state is not IDLE.
err  output  1  one-cycle pulse on an illegal opcode.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state IDLE; all registered outputs 0 (mem_addr, mem_wr_en, mem_rd_en, mem_wdata, out_data, out_valid, err). in_ready=1 and busy=0 follow from IDLE.
- All mem_* outputs, out_data and out_valid are registered. in_ready and busy are decoded from the state register.
- Handshake: a byte transfers on in_valid&&in_ready at a rising edge; likewise out_valid&&out_ready.
- Command byte: [7:6] op, [5:4] len-1 (burst of 1..4 bytes), [3:0] start address.
  - op 10 = WRITE; op 01 = READ; op 00 = NOP (accepted, ignored).
  - op 11 = illegal: accepted, err pulses high for the next cycle only, no memory strobe.
- Internal addr register increments modulo 16 after each burst byte (15 -> 0). The remaining-count register decrements per byte.
- States: IDLE, WDATA, RD_MEM, RD_CAP, RD_OUT.
- IDLE: in_ready=1. On command accept, latch addr and count=len.
  - WRITE -> WDATA.
  - READ -> RD_MEM, with mem_rd_en<=1 and mem_addr<=addr.
  - NOP or illegal -> stay in IDLE.
- WDATA: in_ready=1. Each accepted byte sets mem_wr_en<=1, mem_addr<=addr and mem_wdata<=in_data, so the strobe is visible the cycle after accept. Then addr++ and count--. The last byte -> IDLE.
  - mem_wr_en deasserts the following cycle unless another byte is accepted back-to-back (consecutive cycles allowed).
  - in_valid low simply waits; there is no timeout.
- RD_MEM: mem_rd_en is high this cycle; mem_rd_en<=0 -> RD_CAP.
- RD_CAP: out_data<=mem_rdata, out_valid<=1 -> RD_OUT.
- RD_OUT: in_ready=0. Hold out_data and out_valid until out_ready.
  - On the transfer, out_valid<=0.
  - If bytes remain: addr++, mem_rd_en<=1, mem_addr<=new addr -> RD_MEM. Otherwise -> IDLE.
- Latency: out_valid rises 2 cycles after the READ command accept edge. With out_ready held high, the burst rate is one byte per 3 cycles.
- mem_wr_en and mem_rd_en are never high in the same cycle. mem_rd_en is never re-asserted while out_valid is stalled.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. A partially written burst keeps the bytes already written. A pending read byte is discarded.
- in_ready=0 in RD_MEM, RD_CAP and RD_OUT. Input bytes offered then are not consumed.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> all outputs 0 immediately, in_ready=1, busy=0.
- Single write: cmd 0x83, then data 0xA5 -> one cycle after the data accept, mem_wr_en=1, mem_addr=3, mem_wdata=0xA5 for exactly one cycle. busy drops the next cycle.
- Burst write with wrap: cmd 0xBE (len 4, addr 14), data 0x11,0x22,0x33,0x44 back-to-back -> four consecutive mem_wr_en cycles at addresses 14,15,0,1 with matching data.
- Read with backpressure: after the above, cmd 0x4E with out_ready=0 for 5 cycles -> mem_rd_en single pulse at addr 14. out_valid rises 2 cycles after accept with out_data=0x11 and stays stable. No further mem_rd_en until out_ready=1.
- Burst read: cmd 0x7E (len 4, addr 14), out_ready=1 -> outputs 0x11,0x22,0x33,0x44, each 3 cycles apart. mem_rd_en and mem_wr_en are never high together.
- Illegal/NOP and mid-burst reset: cmd 0xC0 -> err high exactly one cycle, no strobes. cmd 0x00 -> no effect. rst during RD_OUT of a 4-byte read -> out_valid=0, IDLE, next command processed normally.
